// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M div/divu/rem/remu.
// One quotient bit per cycle. Divide-by-zero and signed overflow short-cut
// straight to DONE. Outputs are registered.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     CntW   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CntW-1:0] LastIt = CntW'(XLEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e            state_q;
    logic [1:0]        op_q;
    logic              sign_a_q, sign_b_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvsr_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;

    logic              signed_op;
    logic              div_zero, ovf;
    logic [XLEN-1:0]   a_mag, b_mag, short_res;
    logic [XLEN:0]     rem_shift, diff;
    logic              ge;
    logic [XLEN-1:0]   rem_next, quo_next;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Request decode: operand magnitudes and short-cut detection.
    always_comb begin
        signed_op = ~control[0];
        a_mag     = (signed_op && a[XLEN-1]) ? -a : a;
        b_mag     = (signed_op && b[XLEN-1]) ? -b : b;
        div_zero  = (b == '0);
        ovf       = signed_op && (a == MinVal) && (b == '1);
        if (div_zero) begin
            short_res = control[1] ? a : '1;
        end else begin
            short_res = control[1] ? '0 : MinVal;
        end
    end

    // One restoring step. rem_q < dvsr_q holds between steps, so the shifted
    // value stays below dvsr + 2^XLEN and diff's MSB is a valid borrow flag.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        diff      = rem_shift - {1'b0, dvsr_q};
        ge        = ~diff[XLEN];
        rem_next  = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], ge};
    end

    // Sign correction and quotient/remainder select for the FIX cycle.
    always_comb begin
        quo_fix = (~op_q[0] && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
        rem_fix = (~op_q[0] && sign_a_q) ? -rem_q : rem_q;
        fix_res = op_q[1] ? rem_fix : quo_fix;
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    // kill wins over a same-cycle start
                    if (start && !kill) begin
                        op_q     <= control;
                        sign_a_q <= signed_op & a[XLEN-1];
                        sign_b_q <= signed_op & b[XLEN-1];
                        busy_q   <= 1'b1;
                        if (div_zero || ovf) begin
                            result_q <= short_res;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvsr_q  <= b_mag;
                            cnt_q   <= '0;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (kill) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastIt) begin
                            state_q <= StFix;
                        end
                    end
                end
                StFix: begin
                    if (kill) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider that executes RV32M div/divu/rem/remu.
- Sits directly downstream of the ALU operation decoder. It is enabled when the decoder's select equals 3'b010, and it takes the decoder's 2-bit control as the operation code.
- Multi-cycle. The pipeline stalls on busy and captures result on done.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
control  input  2  00 div, 01 divu, 10 rem, 11 remu (same encoding as decoder output for select=010)
a  input  XLEN  dividend (rs1), sampled with start
b  input  XLEN  divisor (rs2), sampled with start
kill  input  1  synchronous abort (pipeline flush)
busy  output  1  high in RUN, FIX, DONE
done  output  1  one-cycle pulse; result valid
result  output  XLEN  quotient or remainder; held until the next accepted start

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, result=0.
  - Internal registers are cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start=1 at a clock edge:
  - Latch control, a, b.
  - Signed ops (control[0]=0): record sign_a and sign_b. Load the magnitudes |a| and |b|; |0x80000000| = 0x80000000 as unsigned.
  - Unsigned ops: load a and b unchanged.
  - Divide by zero (b==0): go to DONE directly and load result as follows.
    - div/divu: all ones.
    - rem/remu: a.
  - Signed overflow (div or rem, a==0x80000000, b==0xFFFFFFFF): go to DONE directly and load result as follows.
    - div: 0x80000000.
    - rem: 0.
  - Otherwise go to RUN with the iteration count = 0 and the remainder register = 0.
- RUN, one iteration per cycle:
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - If the shifted rem >= divisor magnitude: subtract the divisor and set the quotient LSB to 1.
  - Remainder datapath is XLEN+1 bits wide, so the compare never overflows.
  - After XLEN iterations (count reaches XLEN-1 on the last edge), go to FIX.
- FIX, one cycle:
  - Sign correction, signed ops only:
    - Negate the quotient if sign_a != sign_b.
    - Negate the remainder if sign_a = 1 (remainder takes the dividend's sign).
  - Select the quotient (control[1]=0) or the remainder (control[1]=1) into result.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. result is stable from DONE onward.
- Latency:
  - Normal: done asserts in the cycle after XLEN+2 edges following the start edge, i.e. 34 cycles for XLEN=32.
  - Shortcut (divide by zero or overflow): done asserts after 1 edge.
- Start is ignored while busy=1. No queuing.
- Back-to-back requests: start may be asserted in the cycle after DONE, i.e. in IDLE.
- kill=1 at any edge in RUN or FIX:
  - Go to IDLE. No done pulse. result keeps its previous value.
  - kill in DONE does not suppress the done pulse already being driven.
  - kill has priority over start in IDLE: the request is not accepted.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse.
- Dividend 0 with a nonzero divisor takes the normal path and produces 0 for both quotient and remainder.

Test Plan:
- Signed basics: div 100/7 -> 14; rem 100%-7 -> 2; div -100/7 -> 0xFFFFFFF2; rem -100%7 -> 0xFFFFFFFE. For each, done arrives exactly 34 cycles after start and busy is high throughout.
- Unsigned: divu 0xFFFFFFFF/2 -> 0x7FFFFFFF; remu 0xFFFFFFFF/2 -> 1; divu 0x80000000/0xFFFFFFFF -> 0.
- Divide by zero: div 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; remu 0xDEADBEEF/0 -> 0xDEADBEEF. done arrives 1 cycle after start.
- Overflow: div 0x80000000/0xFFFFFFFF -> 0x80000000; rem on the same operands -> 0. done arrives 1 cycle after start. Contrast: divu on the same operands takes the full 34 cycles and returns 0.
- Handshake:
  - start pulsed again mid-RUN -> ignored; the first result is unchanged.
  - kill at cycle 10 of RUN -> busy drops the next cycle, no done, result holds the prior value.
  - A new start in IDLE then completes normally.
- Reset: assert rst_n=0 asynchronously during RUN -> busy=0, done=0, result=0 immediately. After release, divu 10/3 -> 3.
